// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_pkg
// Description : Command encodings, arbiter state encoding and default widths
//               shared by the command arbiter and the command FIFO wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_TYPE_WIDTH = 2;
    localparam int DEF_ADDR_WIDTH = 27;
    localparam int DEF_BRST_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_MASK_WIDTH = 16;

    localparam logic [1:0] CMD_RD = 2'd0;
    localparam logic [1:0] CMD_WR = 2'd1;

    localparam int         STATE_WIDTH = 2;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_BURST    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first valid requester at or
//               above rr_ptr, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_valid,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any_valid
);

    localparam int c_ID_W = $clog2(N);

    logic [c_ID_W:0]   w_sum;
    logic [c_ID_W-1:0] w_idx;

    // Scan from the far end back toward rr_ptr so the last hit is the nearest.
    always_comb begin
        winner = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_sum = {1'b0, rr_ptr} + (c_ID_W + 1)'(i);
            if (w_sum >= (c_ID_W + 1)'(N)) begin
                w_sum = w_sum - (c_ID_W + 1)'(N);
            end
            w_idx = w_sum[c_ID_W-1:0];
            if (req_valid[w_idx]) begin
                winner = w_idx;
            end
        end
    end

    assign any_valid = |req_valid;

endmodule
`default_nettype wire

// File: rtl/cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmd_arbiter
// Description : Round-robin arbiter sharing the command-FIFO push port; holds
//               the grant across write bursts and while the FIFO stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_arbiter
    import cmd_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int TYPE_WIDTH = DEF_TYPE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BRST_WIDTH = DEF_BRST_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MASK_WIDTH = DEF_MASK_WIDTH
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*TYPE_WIDTH-1:0]    req_cmd_type,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*BRST_WIDTH-1:0]    req_burst_cnt,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wt_data,
    input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_wt_mask,
    output logic                             fifo_push_valid,
    input  logic                             fifo_push_ready,
    output logic [TYPE_WIDTH-1:0]            fifo_cmd_type,
    output logic [ADDR_WIDTH-1:0]            fifo_addr,
    output logic [BRST_WIDTH-1:0]            fifo_burst_cnt,
    output logic [DATA_WIDTH-1:0]            fifo_wt_data,
    output logic [MASK_WIDTH-1:0]            fifo_wt_mask,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             in_burst
);

    localparam int                c_ID_W = $clog2(NUM_REQ);
    localparam logic [c_ID_W-1:0] c_LAST = c_ID_W'(NUM_REQ - 1);

    logic [STATE_WIDTH-1:0] r_state;
    logic [c_ID_W-1:0]      r_rr_ptr;
    logic [c_ID_W-1:0]      r_hold_id;
    logic [BRST_WIDTH-1:0]  r_remain;

    logic [c_ID_W-1:0]      w_winner;
    logic                   w_any;
    logic [c_ID_W-1:0]      w_sel;
    logic                   w_xfer;
    logic                   w_multi;

    function automatic logic [c_ID_W-1:0] f_next(input logic [c_ID_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(.N(NUM_REQ)) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .winner    (w_winner),
        .any_valid (w_any)
    );

    // Requester 0 drives the payload while in reset.
    assign w_sel = !rstn              ? '0 :
                   (r_state == ST_IDLE) ? w_winner : r_hold_id;

    assign fifo_cmd_type  = req_cmd_type [w_sel*TYPE_WIDTH +: TYPE_WIDTH];
    assign fifo_addr      = req_addr     [w_sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign fifo_burst_cnt = req_burst_cnt[w_sel*BRST_WIDTH +: BRST_WIDTH];
    assign fifo_wt_data   = req_wt_data  [w_sel*DATA_WIDTH +: DATA_WIDTH];
    assign fifo_wt_mask   = req_wt_mask  [w_sel*MASK_WIDTH +: MASK_WIDTH];

    assign fifo_push_valid = rstn && ((r_state == ST_IDLE) ? w_any : req_valid[r_hold_id]);
    assign grant_id        = w_sel;
    assign in_burst        = (r_state == ST_BURST);
    assign w_xfer          = fifo_push_valid && fifo_push_ready;
    assign w_multi         = (fifo_cmd_type == TYPE_WIDTH'(CMD_WR)) &&
                             (fifo_burst_cnt > BRST_WIDTH'(1));

    always_comb begin
        req_ready        = '0;
        req_ready[w_sel] = rstn && fifo_push_ready;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_hold_id <= '0;
            r_remain  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_xfer) begin
                        if (w_multi) begin
                            r_state   <= ST_BURST;
                            r_remain  <= fifo_burst_cnt - BRST_WIDTH'(1);
                            r_hold_id <= w_sel;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_rr_ptr <= f_next(w_sel);
                        end
                    end else if (r_state == ST_IDLE) begin
                        // Freeze the choice so the stalled payload stays stable.
                        if (w_any) begin
                            r_state   <= ST_HOLD;
                            r_hold_id <= w_sel;
                        end
                    end else if (!req_valid[r_hold_id]) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (w_xfer) begin
                        if (r_remain <= BRST_WIDTH'(1)) begin
                            r_state  <= ST_IDLE;
                            r_remain <= '0;
                            r_rr_ptr <= f_next(r_hold_id);
                        end else begin
                            r_remain <= r_remain - BRST_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_arbiter
// Description : Directed self-checking bench for cmd_arbiter (NUM_REQ = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_arbiter;
    import cmd_pkg::*;

    localparam int N  = 2;
    localparam int TW = DEF_TYPE_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int BW = DEF_BRST_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int MW = DEF_MASK_WIDTH;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_cmd_type;
    logic [N*AW-1:0] req_addr;
    logic [N*BW-1:0] req_burst_cnt;
    logic [N*DW-1:0] req_wt_data;
    logic [N*MW-1:0] req_wt_mask;
    logic            fifo_push_valid;
    logic            fifo_push_ready;
    logic [TW-1:0]   fifo_cmd_type;
    logic [AW-1:0]   fifo_addr;
    logic [BW-1:0]   fifo_burst_cnt;
    logic [DW-1:0]   fifo_wt_data;
    logic [MW-1:0]   fifo_wt_mask;
    logic            grant_id;
    logic            in_burst;

    int n_cmp = 0;
    int n_err = 0;

    cmd_arbiter dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cmd_type    (req_cmd_type),
        .req_addr        (req_addr),
        .req_burst_cnt   (req_burst_cnt),
        .req_wt_data     (req_wt_data),
        .req_wt_mask     (req_wt_mask),
        .fifo_push_valid (fifo_push_valid),
        .fifo_push_ready (fifo_push_ready),
        .fifo_cmd_type   (fifo_cmd_type),
        .fifo_addr       (fifo_addr),
        .fifo_burst_cnt  (fifo_burst_cnt),
        .fifo_wt_data    (fifo_wt_data),
        .fifo_wt_mask    (fifo_wt_mask),
        .grant_id        (grant_id),
        .in_burst        (in_burst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input logic [DW-1:0] d);
        req_cmd_type [i*TW +: TW] = t;
        req_addr     [i*AW +: AW] = a;
        req_burst_cnt[i*BW +: BW] = b;
        req_wt_data  [i*DW +: DW] = d;
        req_wt_mask  [i*MW +: MW] = MW'(16'hA5A0 + i);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        fifo_push_ready = 1'b1;
        req_valid = 2'b11;
        set_req(0, CMD_RD, 27'h100, 6'd1, 128'h10);
        set_req(1, CMD_RD, 27'h200, 6'd1, 128'h20);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready c=%0d got=%b exp=00", c, req_ready); end
            n_cmp++; if (fifo_push_valid !== 1'b0) begin n_err++; $display("FAIL reset_pvalid c=%0d got=%b exp=0", c, fifo_push_valid); end
            tick();
        end
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        int e;
        fifo_push_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            e = k % 2;
            @(negedge clk);
            n_cmp++; if (grant_id !== 1'(e)) begin n_err++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grant_id, e); end
            n_cmp++; if (fifo_push_valid !== 1'b1) begin n_err++; $display("FAIL rr_pvalid k=%0d got=%b exp=1", k, fifo_push_valid); end
            n_cmp++; if (req_ready !== 2'(1 << e)) begin n_err++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 2'(1 << e)); end
            n_cmp++; if (fifo_addr !== ((e == 0) ? 27'h100 : 27'h200)) begin n_err++; $display("FAIL rr_addr k=%0d got=%h", k, fifo_addr); end
            tick();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_burst();
        logic [DW-1:0] d;
        set_req(0, CMD_WR, 27'h300, 6'd4, 128'hB1);
        set_req(1, CMD_RD, 27'h400, 6'd1, 128'h40);
        req_valid = 2'b11;
        for (int b = 1; b <= 4; b++) begin
            d = DW'(128'hB0 + b);
            req_wt_data[0 +: DW] = d;
            @(negedge clk);
            n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL burst_grant beat=%0d got=%0d exp=0", b, grant_id); end
            n_cmp++; if (in_burst !== (b > 1)) begin n_err++; $display("FAIL burst_flag beat=%0d got=%b exp=%b", b, in_burst, (b > 1)); end
            n_cmp++; if (fifo_wt_data !== d) begin n_err++; $display("FAIL burst_data beat=%0d got=%h exp=%h", b, fifo_wt_data, d); end
            tick();
        end
        req_valid = 2'b10;
        @(negedge clk);
        n_cmp++; if (grant_id !== 1'b1) begin n_err++; $display("FAIL burst_after_grant got=%0d exp=1", grant_id); end
        n_cmp++; if (in_burst !== 1'b0) begin n_err++; $display("FAIL burst_after_flag got=%b exp=0", in_burst); end
        n_cmp++; if (fifo_addr !== 27'h400) begin n_err++; $display("FAIL burst_after_addr got=%h exp=400", fifo_addr); end
        tick();
        req_valid = 2'b00;
    endtask

    task automatic test_stall();
        fifo_push_ready = 1'b0;
        set_req(0, CMD_RD, 27'h600, 6'd1, 128'h60);
        set_req(1, CMD_RD, 27'h500, 6'd1, 128'h50);
        req_valid = 2'b10;
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) req_valid = 2'b11;
            @(negedge clk);
            n_cmp++; if (grant_id !== 1'b1) begin n_err++; $display("FAIL stall_grant c=%0d got=%0d exp=1", c, grant_id); end
            n_cmp++; if (fifo_addr !== 27'h500) begin n_err++; $display("FAIL stall_addr c=%0d got=%h exp=500", c, fifo_addr); end
            n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL stall_ready c=%0d got=%b exp=00", c, req_ready); end
            if (c > 1) begin
                n_cmp++; if (dut.r_state !== ST_HOLD) begin n_err++; $display("FAIL stall_state c=%0d got=%0d exp=%0d", c, dut.r_state, ST_HOLD); end
            end
            tick();
        end
        fifo_push_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (grant_id !== 1'b1) begin n_err++; $display("FAIL stall_release_grant got=%0d exp=1", grant_id); end
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL stall_release_ready got=%b exp=10", req_ready); end
        tick();
        @(negedge clk);
        n_cmp++; if (grant_id !== 1'b0) begin n_err++; $display("FAIL stall_next_grant got=%0d exp=0", grant_id); end
        n_cmp++; if (fifo_addr !== 27'h600) begin n_err++; $display("FAIL stall_next_addr got=%h exp=600", fifo_addr); end
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL stall_next_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        tick();
        req_valid = 2'b00;
    endtask

    task automatic test_burst_zero();
        set_req(1, CMD_WR, 27'h700, 6'd0, 128'h70);
        req_valid = 2'b10;
        @(negedge clk);
        n_cmp++; if (grant_id !== 1'b1) begin n_err++; $display("FAIL bz_grant got=%0d exp=1", grant_id); end
        n_cmp++; if (fifo_push_valid !== 1'b1) begin n_err++; $display("FAIL bz_pvalid got=%b exp=1", fifo_push_valid); end
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL bz_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        n_cmp++; if (in_burst !== 1'b0) begin n_err++; $display("FAIL bz_flag got=%b exp=0", in_burst); end
        n_cmp++; if (dut.r_rr_ptr !== 1'b0) begin n_err++; $display("FAIL bz_rrptr got=%0d exp=0", dut.r_rr_ptr); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        set_req(0, CMD_WR, 27'h800, 6'd4, 128'h80);
        req_valid = 2'b01;
        for (int b = 1; b <= 2; b++) begin
            @(negedge clk);
            n_cmp++; if (in_burst !== (b > 1)) begin n_err++; $display("FAIL rmb_flag beat=%0d got=%b exp=%b", b, in_burst, (b > 1)); end
            tick();
        end
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++; if (fifo_push_valid !== 1'b0) begin n_err++; $display("FAIL rmb_pvalid got=%b exp=0", fifo_push_valid); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rmb_ready got=%b exp=00", req_ready); end
        n_cmp++; if (dut.r_remain !== 6'd2) begin n_err++; $display("FAIL rmb_remain_pre got=%0d exp=2", dut.r_remain); end
        tick();
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (dut.r_state !== ST_IDLE) begin n_err++; $display("FAIL rmb_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
        n_cmp++; if (dut.r_remain !== 6'd0) begin n_err++; $display("FAIL rmb_remain got=%0d exp=0", dut.r_remain); end
        n_cmp++; if (dut.r_rr_ptr !== 1'b0) begin n_err++; $display("FAIL rmb_rrptr got=%0d exp=0", dut.r_rr_ptr); end
        n_cmp++; if (in_burst !== 1'b0) begin n_err++; $display("FAIL rmb_flag_post got=%b exp=0", in_burst); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        rstn            = 1'b0;
        fifo_push_ready = 1'b0;
        req_valid       = '0;
        req_cmd_type    = '0;
        req_addr        = '0;
        req_burst_cnt   = '0;
        req_wt_data     = '0;
        req_wt_mask     = '0;
        test_reset();
        test_round_robin();
        test_burst();
        test_stall();
        test_burst_zero();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
- Shares the single command-FIFO push port among NUM_REQ requesters (e.g. instruction fetch, data port, DMA).
- Picks requesters in round-robin order. Holds the grant across all beats of a multi-beat write burst, so a burst's beats stay contiguous in the FIFO.
- Sits in the push_clk domain, directly in front of the command FIFO's push side. Output fields map one-to-one onto the FIFO push fields.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- TYPE_WIDTH, 2, command type width
- ADDR_WIDTH, 27, address width
- BRST_WIDTH, 6, burst count width
- DATA_WIDTH, 128, write data width
- MASK_WIDTH, 16, write byte-mask width

Ports:
- clk  in  1  clock (the FIFO push clock)
- rstn  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester command/beat valid
- req_ready  out  NUM_REQ  per-requester accept
- req_cmd_type  in  NUM_REQ*TYPE_WIDTH  flattened; requester i occupies slice i
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened
- req_burst_cnt  in  NUM_REQ*BRST_WIDTH  flattened
- req_wt_data  in  NUM_REQ*DATA_WIDTH  flattened
- req_wt_mask  in  NUM_REQ*MASK_WIDTH  flattened
- fifo_push_valid  out  1  to FIFO push valid
- fifo_push_ready  in  1  from FIFO push ready (already low when full or in reset)
- fifo_cmd_type  out  TYPE_WIDTH  muxed field
- fifo_addr  out  ADDR_WIDTH  muxed field
- fifo_burst_cnt  out  BRST_WIDTH  muxed field
- fifo_wt_data  out  DATA_WIDTH  muxed field
- fifo_wt_mask  out  MASK_WIDTH  muxed field
- grant_id  out  $clog2(NUM_REQ)  currently selected requester
- in_burst  out  1  high while in BURST state

Behaviour:
- Reset (rstn low at a clk edge): state=IDLE, rr_ptr=0, remain=0, hold_id=0.
- While rstn is low, req_ready and fifo_push_valid are forced to 0 combinationally. Data outputs are don't-care, but driven from requester 0.
- Transfer on the FIFO side occurs when fifo_push_valid && fifo_push_ready. The granted requester's req_ready equals fifo_push_ready. Every other requester's req_ready is 0.
- Latency is zero: the datapath is a combinational mux from the granted requester to the fifo_* outputs. No data registers.
- Command types (package constants): CMD_RD=0, CMD_WR=1. Types 2 and 3 are single-beat and passed through unchecked.
- A write with burst_cnt=B occupies max(B,1) pushes. Beat 1 carries type/addr/burst_cnt/data/mask. Later beats are read by the consumer for data/mask only; the other fields are passed through as presented.
- IDLE state:
  - The winner is the first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - grant_id = winner. fifo_push_valid = |req_valid.
  - If a transfer occurs and the command is CMD_WR with burst_cnt>1: go to BURST, remain=burst_cnt-1, hold_id=winner.
  - Else if a transfer occurs: stay in IDLE, rr_ptr=winner+1 (mod NUM_REQ).
  - If valid but no transfer (FIFO full): go to HOLD, hold_id=winner. This keeps the FIFO-side payload stable; no re-arbitration while stalled.
- HOLD state:
  - grant_id = hold_id. fifo_push_valid = req_valid[hold_id].
  - On transfer, apply the same next-state rule as IDLE (BURST, or IDLE with rr_ptr update).
  - If the requester drops valid (protocol violation), return to IDLE with rr_ptr unchanged.
- BURST state:
  - grant_id = hold_id. fifo_push_valid = req_valid[hold_id]. No other requester is ever granted.
  - Each transfer decrements remain.
  - A transfer with remain==1 goes to IDLE with rr_ptr=hold_id+1.
  - The grant is held indefinitely if the requester stalls. There is no timeout.
- in_burst = (state==BURST).
- Arithmetic: remain is BRST_WIDTH bits and never underflows. A burst_cnt of 0 is treated as 1.
- rr_ptr wraps modulo NUM_REQ. For non-power-of-two NUM_REQ, the increment compares against NUM_REQ-1.
- Simultaneous events: all-valid in IDLE gives exactly one grant per cycle. A single-beat transfer and a new winner in the next cycle are allowed back-to-back, with no bubble.
- Reset mid-burst: the synchronous reset returns to IDLE. The partial burst in the FIFO is the system's concern, since the FIFO is reset by the same rstn.

Decomposition:
- Package cmd_pkg holds:
  - CMD_RD and CMD_WR
  - the state encoding (IDLE, HOLD, BURST)
  - the default widths, shared with the FIFO wrapper
- One sub-module: rr_pick. It is purely combinational: inputs req_valid and rr_ptr; outputs winner index and any_valid. It is reusable by other arbiters.

Test Plan:
- Reset held low for 3 cycles with all req_valid=1 -> req_ready=0, fifo_push_valid=0. After release, state=IDLE and grant_id=0.
- NUM_REQ=2, both requesters continuously issue CMD_RD, fifo_push_ready=1 -> FIFO receives pushes alternating 0,1,0,1. One push every cycle, no bubbles.
- Req0 issues CMD_WR with burst_cnt=4 while req1 issues reads -> exactly 4 consecutive req0 beats (in_burst high for cycles 2..4), then req1 is granted.
- fifo_push_ready=0 for 5 cycles while req1 is waiting, then req0 also asserts -> state=HOLD, grant_id stays 1, payload stable. Req1 transfers first once ready rises.
- CMD_WR with burst_cnt=0 -> one push, no BURST entry, rr_ptr advances.
- Reset asserted after beat 2 of a 4-beat burst -> next cycle state=IDLE, remain=0, rr_ptr=0.
